// File: rtl/lda_pkg.sv
// lda_pkg: shared types, register map, bit indices and default widths for the line-draw controller
// No ports; imported by the controller and its command FIFO.
package lda_pkg;
    localparam int DEF_XW    = 9;
    localparam int DEF_YW    = 8;
    localparam int DEF_CW    = 3;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT} state_t;

    localparam logic [2:0] ADDR_MODE   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_GO     = 3'd2;
    localparam logic [2:0] ADDR_START  = 3'd3;
    localparam logic [2:0] ADDR_END    = 3'd4;
    localparam logic [2:0] ADDR_COLOR  = 3'd5;

    localparam int MODE_DROP = 0;
    localparam int MODE_IRQ  = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF  = 2;
    localparam int STAT_DONE = 3;

    function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? data[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/lda_cmd_fifo.sv
// lda_cmd_fifo: command FIFO with wrap-around pointers carrying an extra MSB
// Ports: i_clk/i_reset, i_push+i_data write side, i_pop read side, o_data head,
//        o_full/o_empty flags, o_count occupancy.
module lda_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic         do_push, do_pop;

    always_comb begin
        o_count = wr_q - rd_q;
        o_empty = wr_q == rd_q;
        o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        // a push while full is dropped here so the head entry can never be overwritten
        do_push = i_push & ~o_full;
        do_pop  = i_pop & ~o_empty;
        wr_d    = wr_q + (AW+1)'(do_push);
        rd_d    = rd_q + (AW+1)'(do_pop);
        o_data  = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/lda_avalon_queued_controller.sv
// lda_avalon_queued_controller: Avalon-MM slave queuing line-draw commands for an LDA core
// Ports: i_clk/i_reset; Avalon slave (i_address, i_read, i_write, i_chipselect,
//        i_byteenable, i_writedata, o_readdata, o_waitrequest); LDA side
//        (o_x0/o_y0/o_x1/o_y1/o_color, o_start, i_done); o_irq level interrupt.
module lda_avalon_queued_controller
    import lda_pkg::*;
#(
    parameter int XW    = DEF_XW,
    parameter int YW    = DEF_YW,
    parameter int CW    = DEF_CW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [2:0]    i_address,
    input  logic          i_read,
    input  logic          i_write,
    input  logic          i_chipselect,
    input  logic [3:0]    i_byteenable,
    input  logic [31:0]   i_writedata,
    output logic [31:0]   o_readdata,
    output logic          o_waitrequest,
    output logic [XW-1:0] o_x0,
    output logic [YW-1:0] o_y0,
    output logic [XW-1:0] o_x1,
    output logic [YW-1:0] o_y1,
    output logic [CW-1:0] o_color,
    output logic          o_start,
    input  logic          i_done,
    output logic          o_irq
);
    localparam int PW = XW + YW;
    localparam int FW = 2*PW + CW;
    localparam int AW = $clog2(DEPTH);

    logic [1:0]    mode_q, mode_d;
    logic [PW-1:0] start_q, start_d, end_q, end_d;
    logic [CW-1:0] color_q, color_d;
    logic          ovf_q, ovf_d, done_q, done_d;
    state_t        state_q, state_d;
    logic          start_pulse_q, start_pulse_d;
    logic [XW-1:0] x0_q, x0_d, x1_q, x1_d;
    logic [YW-1:0] y0_q, y0_d, y1_q, y1_d;
    logic [CW-1:0] col_q, col_d;

    logic          wr, go_wr, clr, push, pop, full, empty, busy, done_set;
    logic [AW:0]   count;
    logic [FW-1:0] head;
    logic [PW-1:0] head_start, head_end;
    logic [31:0]   rd;

    lda_cmd_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_data  ({start_q, end_q, color_q}),
        .i_pop   (pop),
        .o_data  (head),
        .o_full  (full),
        .o_empty (empty),
        .o_count (count)
    );

    always_comb begin
        wr            = i_chipselect & i_write;
        go_wr         = wr & (i_address == ADDR_GO);
        o_waitrequest = go_wr & full & ~mode_q[MODE_DROP];
        // in drop mode a GO while full completes on the bus but never reaches the FIFO
        push          = go_wr & ~full;
        clr           = wr & (i_address == ADDR_STATUS) & i_byteenable[0];
        mode_d        = (wr && i_address == ADDR_MODE && i_byteenable[0]) ? i_writedata[1:0] : mode_q;
        start_d       = (wr && i_address == ADDR_START) ? PW'(be_merge(32'(start_q), i_writedata, i_byteenable)) : start_q;
        end_d         = (wr && i_address == ADDR_END) ? PW'(be_merge(32'(end_q), i_writedata, i_byteenable)) : end_q;
        color_d       = (wr && i_address == ADDR_COLOR) ? CW'(be_merge(32'(color_q), i_writedata, i_byteenable)) : color_q;
        done_set      = (state_q == ST_WAIT) & i_done & empty & ~push;
        // set events win over a coincident write-1-to-clear
        ovf_d         = (go_wr & full & mode_q[MODE_DROP]) | (ovf_q & ~(clr & i_writedata[STAT_OVF]));
        done_d        = done_set | (done_q & ~(clr & i_writedata[STAT_DONE]));
        state_d       = state_q;
        pop           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pop     = ~empty;
                state_d = empty ? ST_IDLE : ST_START;
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  state_d = i_done ? ST_IDLE : ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
        // registered so the draw request lands two cycles after a GO into an idle, empty queue
        start_pulse_d = state_q == ST_START;
        head_start    = head[FW-1 -: PW];
        head_end      = head[CW +: PW];
        x0_d          = pop ? head_start[XW-1:0] : x0_q;
        y0_d          = pop ? head_start[PW-1:XW] : y0_q;
        x1_d          = pop ? head_end[XW-1:0] : x1_q;
        y1_d          = pop ? head_end[PW-1:XW] : y1_q;
        col_d         = pop ? head[CW-1:0] : col_q;
        busy          = (state_q != ST_IDLE) | ~empty;
        case (i_address)
            ADDR_MODE:   rd = 32'(mode_q);
            ADDR_STATUS: rd = {16'b0, 8'(count), 4'b0, done_q, ovf_q, full, busy};
            ADDR_START:  rd = 32'(start_q);
            ADDR_END:    rd = 32'(end_q);
            ADDR_COLOR:  rd = 32'(color_q);
            default:     rd = 32'b0;
        endcase
        o_readdata    = (i_chipselect & i_read) ? rd : 32'b0;
        o_irq         = done_q & mode_q[MODE_IRQ];
        o_start       = start_pulse_q;
        o_x0          = x0_q;
        o_y0          = y0_q;
        o_x1          = x1_q;
        o_y1          = y1_q;
        o_color       = col_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mode_q        <= '0;
            start_q       <= '0;
            end_q         <= '0;
            color_q       <= '0;
            ovf_q         <= 1'b0;
            done_q        <= 1'b0;
            state_q       <= ST_IDLE;
            start_pulse_q <= 1'b0;
            x0_q          <= '0;
            y0_q          <= '0;
            x1_q          <= '0;
            y1_q          <= '0;
            col_q         <= '0;
        end else begin
            mode_q        <= mode_d;
            start_q       <= start_d;
            end_q         <= end_d;
            color_q       <= color_d;
            ovf_q         <= ovf_d;
            done_q        <= done_d;
            state_q       <= state_d;
            start_pulse_q <= start_pulse_d;
            x0_q          <= x0_d;
            y0_q          <= y0_d;
            x1_q          <= x1_d;
            y1_q          <= y1_d;
            col_q         <= col_d;
        end
    end
endmodule

// File: tb/tb_lda_avalon_queued_controller.sv
// tb_lda_avalon_queued_controller: directed self-checking bench for the queued line-draw controller
module tb_lda_avalon_queued_controller;
    import lda_pkg::*;

    logic        clk, rst, rd_en, wr_en, cs, done_in;
    logic [2:0]  addr;
    logic [3:0]  ben;
    logic [31:0] wdata, rdata;
    logic        wreq, start, irq;
    logic [8:0]  x0, x1;
    logic [7:0]  y0, y1;
    logic [2:0]  color;
    int          n_chk, n_pass;
    logic [31:0] r;
    int          waits;
    logic        seen;

    lda_avalon_queued_controller dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_address     (addr),
        .i_read        (rd_en),
        .i_write       (wr_en),
        .i_chipselect  (cs),
        .i_byteenable  (ben),
        .i_writedata   (wdata),
        .o_readdata    (rdata),
        .o_waitrequest (wreq),
        .o_x0          (x0),
        .o_y0          (y0),
        .o_x1          (x1),
        .o_y1          (y1),
        .o_color       (color),
        .o_start       (start),
        .i_done        (done_in),
        .o_irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be, output int w);
        w = 0;
        @(negedge clk);
        cs = 1; wr_en = 1; addr = a; wdata = d; ben = be;
        #1;
        while (wreq && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (wreq) check("wr_timeout", 1, 0);
        @(posedge clk);
        #1;
        cs = 0; wr_en = 0;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        int w;
        bus_wr(a, d, 4'hF, w);
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1; rd_en = 1; addr = a;
        #1;
        d = rdata;
        cs = 0; rd_en = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done_in = 1;
        @(negedge clk);
        done_in = 0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 0; rd_en = 0; wr_en = 0; cs = 0; done_in = 0;
        addr = 0; ben = 0; wdata = 0;
        do_reset();
        check("rst_start", start, 0);
        check("rst_irq", irq, 0);
        check("rst_wreq", wreq, 0);
        check("rst_coords", {x0, y0, x1, y1, color}, 0);
        bus_rd(ADDR_STATUS, r); check("rst_status", r, 0);
        bus_rd(ADDR_MODE, r);   check("rst_mode", r, 0);

        // single line: start (10,20) end (100,50) colour 5
        wr_reg(ADDR_START, (20 << 9) | 10);
        wr_reg(ADDR_END, (50 << 9) | 100);
        wr_reg(ADDR_COLOR, 5);
        bus_rd(ADDR_START, r); check("rb_start", r, 32'd10250);
        wr_reg(ADDR_GO, 32'hDEAD);
        @(negedge clk); check("lat_e0", start, 0);
        @(negedge clk); check("lat_e1", start, 0);
        @(negedge clk); check("lat_e2", start, 1);
        check("x0", x0, 10);
        check("y0", y0, 20);
        check("x1", x1, 100);
        check("y1", y1, 50);
        check("color", color, 5);
        @(negedge clk); check("lat_e3", start, 0);
        pulse_done();
        bus_rd(ADDR_STATUS, r); check("single_done", r, 32'h8);
        check("single_irq_off", irq, 0);
        check("hold_x1", x1, 100);

        // stall mode back-pressure
        do_reset();
        for (int i = 0; i < 5; i++) wr_reg(ADDR_GO, 0);
        bus_rd(ADDR_STATUS, r); check("stall_status_full", r, 32'h0403);
        @(negedge clk);
        cs = 1; wr_en = 1; addr = ADDR_GO; wdata = 0; ben = 4'hF;
        #1; check("stall_wreq0", wreq, 1);
        repeat (2) @(negedge clk);
        check("stall_wreq2", wreq, 1);
        done_in = 1;
        @(negedge clk);
        done_in = 0;
        check("stall_after_done", wreq, 1);
        @(negedge clk); check("stall_after_pop", wreq, 0);
        @(posedge clk); #1;
        cs = 0; wr_en = 0;
        bus_rd(ADDR_STATUS, r); check("stall_accepted", r, 32'h0403);

        // drop mode overflow
        do_reset();
        wr_reg(ADDR_MODE, 1);
        for (int i = 0; i < 5; i++) wr_reg(ADDR_GO, 0);
        bus_wr(ADDR_GO, 0, 4'hF, waits); check("drop_nowait", waits, 0);
        bus_rd(ADDR_STATUS, r); check("drop_ovf", r, 32'h0407);
        wr_reg(ADDR_STATUS, 32'h4);
        bus_rd(ADDR_STATUS, r); check("drop_ovf_clr", r, 32'h0403);

        // done and interrupt after the last of two lines
        do_reset();
        wr_reg(ADDR_MODE, 2);
        wr_reg(ADDR_GO, 0);
        wr_reg(ADDR_GO, 0);
        repeat (3) @(negedge clk);
        pulse_done();
        bus_rd(ADDR_STATUS, r); check("irq_first_done", r, 32'h1);
        check("irq_first_off", irq, 0);
        repeat (3) @(negedge clk);
        pulse_done();
        bus_rd(ADDR_STATUS, r); check("irq_second_done", r, 32'h8);
        check("irq_on", irq, 1);
        wr_reg(ADDR_STATUS, 32'h8);
        check("irq_cleared", irq, 0);

        // reset mid-draw with three queued, then a stale done
        do_reset();
        for (int i = 0; i < 4; i++) wr_reg(ADDR_GO, 0);
        bus_rd(ADDR_STATUS, r); check("middraw_queue", r, 32'h0301);
        do_reset();
        seen = 0;
        done_in = 1;
        @(negedge clk);
        done_in = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | start;
        end
        check("middraw_no_start", seen, 0);
        bus_rd(ADDR_STATUS, r); check("middraw_status", r, 0);

        // byte lanes and unmapped addresses
        wr_reg(ADDR_START, 32'h02345);
        bus_wr(ADDR_START, 32'hFF, 4'b0001, waits);
        bus_rd(ADDR_START, r); check("be_lane0", r, 32'h023FF);
        bus_wr(ADDR_START, 32'hFFFFFFFF, 4'b0100, waits);
        bus_rd(ADDR_START, r); check("be_lane2", r, 32'h123FF);
        wr_reg(ADDR_MODE, 32'hFF);
        bus_rd(ADDR_MODE, r); check("mode_mask", r, 32'h3);
        wr_reg(3'd6, 32'hFFFFFFFF);
        bus_rd(3'd6, r); check("addr6", r, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
